barrelshifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational barrel shifter.
- Keeps the same op encoding and zero/overflow flags, and adds a carry flag.
- Splits the shift into $clog2(D_SIZE) registered stages with a valid/ready handshake on both sides.
- Sits between an issue stage and a writeback consumer, and can accept one operation per cycle.

---
 rtl/barrelshifter_pipe.sv | 184 ++++++++++++++++++
 tb/tb_barrelshifter_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrelshifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with valid/ready on both sides.
// Optional macro BSHIFT_BUBBLE_COLLAPSE_EN gives each stage its own load enable so bubbles are squeezed out.
module barrelshifter_pipe #(
  parameter int unsigned D_SIZE = 32,
  parameter int unsigned S_SIZE = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [S_SIZE-1:0] s_in,
  input  logic [2:0]        op_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out,
  output logic              cf_out
);

  localparam int unsigned L = S_SIZE;

  typedef enum logic [2:0] {
    OP_SRL     = 3'b000,
    OP_SRA     = 3'b001,
    OP_ROR     = 3'b010,
    OP_ROR_ALT = 3'b011,
    OP_SLL     = 3'b100,
    OP_SLA     = 3'b101,
    OP_ROL     = 3'b110,
    OP_ROL_ALT = 3'b111
  } op_e;

  function automatic logic [D_SIZE-1:0] shift_step(input logic [D_SIZE-1:0] d,
                                                   input op_e op,
                                                   input int unsigned amt);
    logic [D_SIZE-1:0]        r;
    logic signed [D_SIZE-1:0] sd;
    logic [D_SIZE-2:0]        lo;
    sd = d;
    lo = d[D_SIZE-2:0] << amt;
    r  = d;
    case (op)
      OP_SRL:             r = d >> amt;
      OP_SRA:             r = sd >>> amt;
      OP_ROR, OP_ROR_ALT: r = (d >> amt) | (d << (D_SIZE - amt));
      OP_SLL:             r = d << amt;
      OP_SLA:             r = {d[D_SIZE-1], lo};
      OP_ROL, OP_ROL_ALT: r = (d << amt) | (d >> (D_SIZE - amt));
    endcase
    return r;
  endfunction

  // Bits leaving the magnitude field of an SLA step are d[D-2 : D-1-amt]; any that differ from the sign overflow.
  function automatic logic sla_lost(input logic [D_SIZE-1:0] d, input int unsigned amt);
    logic [D_SIZE-1:0] mask;
    mask = '1;
    mask = (mask >> (D_SIZE - amt)) << (D_SIZE - 1 - amt);
    return |((d ^ {D_SIZE{d[D_SIZE-1]}}) & mask);
  endfunction

  logic [L-1:0]        en;
  logic [L-1:0]        stage_vld;
  logic [S_SIZE-1:0]   s_m1;
  logic                cf0;
  logic                zf_q;

  // x[s-1] for right ops, x[D-s] for left ops; D-s equals ~(s-1) within S_SIZE bits.
  always_comb begin
    s_m1 = s_in - S_SIZE'(1);
    cf0  = 1'b0;
    if (s_in != '0) begin
      cf0 = op_in[2] ? x_in[~s_m1] : x_in[s_m1];
    end
  end

`ifdef BSHIFT_BUBBLE_COLLAPSE_EN
  always_comb begin
    logic nxt_load;
    en       = '0;
    nxt_load = out_ready_in;
    for (int unsigned i = 0; i < L; i++) begin
      en[L-1-i] = !stage_vld[L-1-i] || nxt_load;
      nxt_load  = en[L-1-i];
    end
  end
`else
  always_comb begin
    en = {L{!out_valid_out || out_ready_in}};
  end
`endif

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int unsigned AMT = 1 << k;

    logic                s_vld;
    logic [D_SIZE-1:0]   s_dat;
    op_e                 s_op;
    logic [S_SIZE-1-k:0] s_rem;
    logic                s_cf;
    logic                s_vf;
    logic [D_SIZE-1:0]   dat_d;
    logic                vf_d;
    logic                vld_q;
    logic [D_SIZE-1:0]   dat_q;
    logic                cf_q;
    logic                vf_q;

    if (k == 0) begin : g_src
      assign s_vld = in_valid_in;
      assign s_dat = x_in;
      assign s_op  = op_e'(op_in);
      assign s_rem = s_in;
      assign s_cf  = cf0;
      assign s_vf  = 1'b0;
    end else begin : g_src
      assign s_vld = g_stage[k-1].vld_q;
      assign s_dat = g_stage[k-1].dat_q;
      assign s_op  = g_stage[k-1].g_mid.op_q;
      assign s_rem = g_stage[k-1].g_mid.rem_q;
      assign s_cf  = g_stage[k-1].cf_q;
      assign s_vf  = g_stage[k-1].vf_q;
    end

    always_comb begin
      dat_d = s_dat;
      vf_d  = s_vf;
      if (s_rem[0]) begin
        dat_d = shift_step(s_dat, s_op, AMT);
        vf_d  = s_vf | ((s_op == OP_SLA) && sla_lost(s_dat, AMT));
      end
    end

    // Payload only loads with a valid op so idle outputs keep their last value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        cf_q  <= 1'b0;
        vf_q  <= 1'b0;
      end else if (en[k]) begin
        vld_q <= s_vld;
        if (s_vld) begin
          dat_q <= dat_d;
          cf_q  <= s_cf;
          vf_q  <= vf_d;
        end
      end
    end

    if (k < L-1) begin : g_mid
      op_e                 op_q;
      logic [S_SIZE-2-k:0] rem_q;
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          op_q  <= OP_SRL;
          rem_q <= '0;
        end else if (en[k] && s_vld) begin
          op_q  <= s_op;
          rem_q <= s_rem[S_SIZE-1-k:1];
        end
      end
    end

    assign stage_vld[k] = vld_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      zf_q <= 1'b0;
    end else if (en[L-1] && g_stage[L-1].s_vld) begin
      zf_q <= ~|g_stage[L-1].dat_d;
    end
  end

  assign in_ready_out  = en[0];
  assign out_valid_out = stage_vld[L-1];
  assign y_out         = g_stage[L-1].dat_q;
  assign zf_out        = zf_q;
  assign vf_out        = g_stage[L-1].vf_q;
  assign cf_out        = g_stage[L-1].cf_q;

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Self-checking bench for barrelshifter_pipe at D_SIZE = 8: vector table, scoreboard, stall and reset sequences.
module tb_barrelshifter_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [2:0] s_in;
  logic [2:0] op_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_out;
  logic       zf_out, vf_out, cf_out;

  always #5 clk = ~clk;

  barrelshifter_pipe #(.D_SIZE(8)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .x_in          (x_in),
    .s_in          (s_in),
    .op_in         (op_in),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready),
    .y_out         (y_out),
    .zf_out        (zf_out),
    .vf_out        (vf_out),
    .cf_out        (cf_out)
  );

  typedef struct {
    logic [7:0] x;
    logic [2:0] s;
    logic [2:0] op;
    logic [7:0] y;
    logic       zf;
    logic       vf;
    logic       cf;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       zf;
    logic       vf;
    logic       cf;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    exp_t        e;
    int          sh;
    logic [15:0] dbl;
    logic [15:0] t;
    sh  = int'(s);
    dbl = {x, x};
    e.y = '0;
    if (op[1]) begin
      if (op[2]) begin t = dbl << sh; e.y = t[15:8]; end
      else       begin t = dbl >> sh; e.y = t[7:0];  end
    end else if (!op[2]) begin
      if (op[0]) begin
        for (int i = 0; i < 8; i++) e.y[i] = (i + sh < 8) ? x[i + sh] : x[7];
      end else begin
        e.y = x >> sh;
      end
    end else if (op[0]) begin
      e.y[7] = x[7];
      for (int i = 0; i < 7; i++) e.y[i] = (i >= sh) ? x[i - sh] : 1'b0;
    end else begin
      e.y = x << sh;
    end
    e.cf = 1'b0;
    if (sh != 0) e.cf = op[2] ? x[8 - sh] : x[sh - 1];
    e.vf = 1'b0;
    if (op == 3'b101) begin
      for (int i = 7 - sh; i <= 6; i++) if (x[i] != x[7]) e.vf = 1'b1;
    end
    e.zf = (e.y == 8'h00);
    return e;
  endfunction

  task automatic send(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op, input exp_t e);
    logic acc;
    in_valid = 1'b1;
    x_in     = x;
    s_in     = s;
    op_in    = op;
    sb.push_back(e);
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("y",  y_out,  e.y);
        check("zf", zf_out, e.zf);
        check("vf", vf_out, e.vf);
        check("cf", cf_out, e.cf);
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    vec_t       tbl[$];
    exp_t       e;
    exp_t       ops_e[6];
    logic [7:0] ops_x[6];
    logic [2:0] ops_s[6];
    logic [2:0] ops_op[6];
    logic [7:0] snap_y;
    logic       snap_zf, snap_vf, snap_cf;
    int         lat, idx, accepted, exp_acc;
    logic       exp_rdy_stall;

    tbl.push_back('{8'h90, 3'd3, 3'b001, 8'hF2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h50, 3'd1, 3'b101, 8'h20, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8'hC0, 3'd1, 3'b101, 8'h80, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{8'h81, 3'd7, 3'b010, 8'h03, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 3'd7, 3'b100, 8'h80, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{8'h80, 3'd7, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h81, 3'd7, 3'b101, 8'h80, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8'h80, 3'd7, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h0F, 3'd4, 3'b111, 8'hF0, 1'b0, 1'b0, 1'b0});
    for (int o = 0; o < 8; o++) begin
      logic [2:0] opv;
      opv = 3'(o);
      tbl.push_back('{8'hA5, 3'd0, opv, 8'hA5, 1'b0, 1'b0, 1'b0});
    end

`ifdef BSHIFT_BUBBLE_COLLAPSE_EN
    exp_rdy_stall = 1'b1;
    exp_acc       = 2;
`else
    exp_rdy_stall = 1'b0;
    exp_acc       = 0;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    s_in      = '0;
    op_in     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_zf", zf_out, 0);
    check("rst_vf", vf_out, 0);
    check("rst_cf", cf_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 1);

    // Latency of a lone op into an empty pipe, counting the transfer edge.
    out_ready = 1'b1;
    e = '{tbl[0].y, tbl[0].zf, tbl[0].vf, tbl[0].cf};
    send(tbl[0].x, tbl[0].s, tbl[0].op, e);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    drain();

    for (int i = 1; i < tbl.size(); i++) begin
      e = '{tbl[i].y, tbl[i].zf, tbl[i].vf, tbl[i].cf};
      send(tbl[i].x, tbl[i].s, tbl[i].op, e);
    end
    drain();

    // ROL then SRL back to back: results on consecutive cycles.
    out_cyc.delete();
    send(8'h81, 3'd1, 3'b110, '{8'h03, 1'b0, 1'b0, 1'b1});
    send(8'h01, 3'd1, 3'b000, '{8'h00, 1'b1, 1'b0, 1'b1});
    drain();
    check("pair_count", out_cyc.size(), 2);
    if (out_cyc.size() == 2) check("pair_gap", out_cyc[1] - out_cyc[0], 1);

    // Backpressure: one op reaches the output while the consumer is stalled.
    for (int i = 0; i < 6; i++) begin
      ops_x[i]  = 8'($urandom_range(0, 255));
      ops_s[i]  = 3'($urandom_range(1, 7));
      ops_op[i] = 3'(i + 1);
      ops_e[i]  = model(ops_x[i], ops_s[i], ops_op[i]);
    end
    out_ready = 1'b0;
    send(ops_x[0], ops_s[0], ops_op[0], ops_e[0]);
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("ready_with_out_ready", in_ready, 1);
    out_ready = 1'b0;
    #1;
    check("ready_on_stall", in_ready, exp_rdy_stall);
    snap_y  = y_out;
    snap_zf = zf_out;
    snap_vf = vf_out;
    snap_cf = cf_out;
    check("stall_first_y", snap_y, ops_e[0].y);
    idx      = 1;
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      x_in     = ops_x[idx];
      s_in     = ops_s[idx];
      op_in    = ops_op[idx];
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_y", y_out, snap_y);
      check("stall_zf", zf_out, snap_zf);
      check("stall_vf", vf_out, snap_vf);
      check("stall_cf", cf_out, snap_cf);
      if (in_ready) begin
        sb.push_back(ops_e[idx]);
        idx++;
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_accepted", accepted, exp_acc);
    check("ready_full_stall", in_ready, 0);
    out_ready = 1'b1;
    while (idx < 6) begin
      send(ops_x[idx], ops_s[idx], ops_op[idx], ops_e[idx]);
      idx++;
    end
    drain();

    // Reset with two ops in flight: one presented at the output, one behind it.
    out_ready = 1'b0;
    send(8'h50, 3'd1, 3'b101, model(8'h50, 3'd1, 3'b101));
    send(8'h81, 3'd1, 3'b110, model(8'h81, 3'd1, 3'b110));
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_y", y_out, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y_out, 0);
    check("mid_rst_zf", zf_out, 0);
    check("mid_rst_vf", vf_out, 0);
    check("mid_rst_cf", cf_out, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_rst", in_ready, 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_ghost_output", out_valid, 0);
    check("sb_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
